mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/rv32i_types.sv | 20 ++
 rtl/arb_sat_counter.sv | 24 ++
 rtl/mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared types and helpers for the I/D cache memory arbiter.
package rv32i_types;

  localparam int CACHE_LINE_W = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  // Clears the line-offset bits of a byte address.
  function automatic logic [31:0] line_align(input logic [31:0] addr, input int unsigned offset_w);
    logic [31:0] mask_s;
    mask_s = 32'hFFFF_FFFF << offset_w;
    return addr & mask_s;
  endfunction

endpackage

// File: rtl/arb_sat_counter.sv
// 32-bit event counter that sticks at its maximum value instead of wrapping.
module arb_sat_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] count
);

  logic [31:0] count_r;

  // Count completion pulses, holding once the all-ones value is reached.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= 32'd0;
    end else if (inc && (count_r != 32'hFFFF_FFFF)) begin
      count_r <= count_r + 32'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache fills and D-cache fills/writebacks onto one physical memory port.
// Optional macro MEM_ARB_RR_EN selects round-robin instead of fixed D priority.
module mem_arbiter
  import rv32i_types::*;
#(
  parameter int LINE_W   = CACHE_LINE_W,
  parameter int OFFSET_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [31:0]       i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [31:0]       d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic [31:0]       i_grant_cnt,
  output logic [31:0]       d_grant_cnt
);

  arb_state_t  state_r;
  arb_state_t  state_s;
  logic [31:0] addr_r;
  logic        write_r;
  logic        grant_i_s;
  logic        grant_d_s;
  logic        d_req_s;

  assign d_req_s = d_read | d_write;

`ifdef MEM_ARB_RR_EN
  logic last_grant_r;  // 1'b0: D granted last, 1'b1: I granted last

  // Round-robin choice in IDLE; a lone requester always wins.
  always_comb begin
    grant_i_s = 1'b0;
    grant_d_s = 1'b0;
    if (state_r == IDLE) begin
      if (d_req_s && i_read) begin
        grant_i_s = ~last_grant_r;
        grant_d_s = last_grant_r;
      end else begin
        grant_d_s = d_req_s;
        grant_i_s = i_read & ~d_req_s;
      end
    end else begin
      grant_i_s = 1'b0;
      grant_d_s = 1'b0;
    end
  end

  // Remember which side won the most recent grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_r <= 1'b0;
    end else if (grant_i_s) begin
      last_grant_r <= 1'b1;
    end else if (grant_d_s) begin
      last_grant_r <= 1'b0;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end
`else
  // Fixed priority in IDLE: D-cache ahead of I-cache.
  always_comb begin
    grant_i_s = 1'b0;
    grant_d_s = 1'b0;
    if (state_r == IDLE) begin
      grant_d_s = d_req_s;
      grant_i_s = i_read & ~d_req_s;
    end else begin
      grant_i_s = 1'b0;
      grant_d_s = 1'b0;
    end
  end
`endif

  // Next state and memory/response outputs; commands only leave the SERVE states.
  always_comb begin
    state_s      = state_r;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = 32'd0;
    pmem_wdata   = {LINE_W{1'b0}};
    i_resp       = 1'b0;
    d_resp       = 1'b0;
    i_rdata      = {LINE_W{1'b0}};
    d_rdata      = {LINE_W{1'b0}};
    case (state_r)
      IDLE: begin
        if (grant_d_s) begin
          state_s = SERVE_D;
        end else if (grant_i_s) begin
          state_s = SERVE_I;
        end else begin
          state_s = IDLE;
        end
      end
      SERVE_I: begin
        pmem_read    = 1'b1;
        pmem_address = addr_r;
        i_resp       = pmem_resp;
        i_rdata      = pmem_rdata;
        state_s      = pmem_resp ? DONE : SERVE_I;
      end
      SERVE_D: begin
        pmem_write   = write_r;
        pmem_read    = ~write_r;
        pmem_address = addr_r;
        pmem_wdata   = write_r ? d_wdata : {LINE_W{1'b0}};
        d_resp       = pmem_resp;
        d_rdata      = pmem_rdata;
        state_s      = pmem_resp ? DONE : SERVE_D;
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register plus the address/operation captured at grant time.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      addr_r  <= 32'd0;
      write_r <= 1'b0;
    end else begin
      state_r <= state_s;
      if (grant_d_s) begin
        addr_r  <= line_align(d_address, OFFSET_W);
        write_r <= d_write;
      end else if (grant_i_s) begin
        addr_r  <= line_align(i_address, OFFSET_W);
        write_r <= 1'b0;
      end else begin
        addr_r  <= addr_r;
        write_r <= write_r;
      end
    end
  end

  arb_sat_counter u_i_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (i_resp),
    .count (i_grant_cnt)
  );

  arb_sat_counter u_d_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (d_resp),
    .count (d_grant_cnt)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter against a transaction-level model.
module tb_mem_arbiter;

  localparam int LW = 256;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read, d_read, d_write, pmem_resp;
  logic [31:0]   i_address, d_address;
  logic [LW-1:0] d_wdata, pmem_rdata;
  logic [LW-1:0] i_rdata, d_rdata, pmem_wdata;
  logic          i_resp, d_resp, pmem_read, pmem_write;
  logic [31:0]   pmem_address, i_grant_cnt, d_grant_cnt;

  always #5 clk = ~clk;

  mem_arbiter #(.LINE_W(LW), .OFFSET_W(5)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt)
  );

  int total = 0;
  int bad = 0;

  // Model: who owns memory (0 none, 1 I, 2 D), dead cycles left, captured transaction.
  int          m_owner = 0;
  int          m_gap = 0;
  int          lat_left = 0;
  logic        m_wr = 1'b0;
  logic [31:0] m_addr = 32'd0;
  logic [31:0] m_icnt = 32'd0;
  logic [31:0] m_dcnt = 32'd0;
  logic        m_last_i = 1'b0;
  bit          m_i_done = 1'b0;
  bit          m_d_done = 1'b0;
  bit          i_late = 1'b0;
  bit          d_late = 1'b0;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Sample point mid-cycle: compare every output against the model.
  task automatic settle();
    logic [LW-1:0] zero_line;
    zero_line = '0;
    #2;
    chk("pmem_read", LW'(pmem_read), LW'((m_owner == 1) || (m_owner == 2 && !m_wr)));
    chk("pmem_write", LW'(pmem_write), LW'(m_owner == 2 && m_wr));
    chk("pmem_address", LW'(pmem_address), LW'((m_owner != 0) ? m_addr : 32'd0));
    chk("pmem_wdata", pmem_wdata, (m_owner == 2 && m_wr) ? d_wdata : zero_line);
    chk("i_resp", LW'(i_resp), LW'(m_owner == 1 && pmem_resp));
    chk("d_resp", LW'(d_resp), LW'(m_owner == 2 && pmem_resp));
    chk("i_rdata", i_rdata, (m_owner == 1) ? pmem_rdata : zero_line);
    chk("d_rdata", d_rdata, (m_owner == 2) ? pmem_rdata : zero_line);
    chk("i_grant_cnt", LW'(i_grant_cnt), LW'(m_icnt));
    chk("d_grant_cnt", LW'(d_grant_cnt), LW'(m_dcnt));
  endtask

  // Apply the arbitration rules to this cycle's inputs, then move to the next cycle.
  task automatic adv();
    int pick;
    pick = 0;
    if (rst) begin
      m_owner = 0; m_gap = 0; m_icnt = 32'd0; m_dcnt = 32'd0; m_last_i = 1'b0;
    end else if (m_owner != 0) begin
      if (pmem_resp) begin
        if (m_owner == 1) begin
          if (m_icnt != 32'hFFFF_FFFF) m_icnt = m_icnt + 32'd1;
          m_i_done = 1'b1;
        end else begin
          if (m_dcnt != 32'hFFFF_FFFF) m_dcnt = m_dcnt + 32'd1;
          m_d_done = 1'b1;
        end
        m_owner = 0;
        m_gap = 1;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      if ((d_read || d_write) && i_read) pick = (RR && !m_last_i) ? 1 : 2;
      else if (d_read || d_write) pick = 2;
      else if (i_read) pick = 1;
      if (pick == 2) begin
        m_owner = 2; m_addr = d_address & 32'hFFFF_FFE0; m_wr = d_write; m_last_i = 1'b0;
      end else if (pick == 1) begin
        m_owner = 1; m_addr = i_address & 32'hFFFF_FFE0; m_wr = 1'b0; m_last_i = 1'b1;
      end
      if (pick != 0) lat_left = $urandom_range(0, 3);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    settle();
    adv();
    rst = 1'b0;
  endtask

  task automatic wait_resp(input int lat, input logic [LW-1:0] data, input int who);
    pmem_resp = 1'b0;
    repeat (lat) begin settle(); adv(); end
    pmem_resp = 1'b1;
    pmem_rdata = data;
    settle();
    chk("resp_i_pulse", LW'(i_resp), LW'(who == 1));
    chk("resp_d_pulse", LW'(d_resp), LW'(who == 2));
    if (who == 1) chk("fill_i", i_rdata, data);
    else chk("fill_d", d_rdata, data);
    adv();
    pmem_resp = 1'b0;
    pmem_rdata = '0;
  endtask

  initial begin
    logic [LW-1:0] aa5;
    logic [LW-1:0] line;
    logic [31:0]   first_addr, second_addr;
    int            first_who, second_who;
    int            op;

    aa5 = {32{8'hA5}};
    rst = 1'b1; i_read = 1'b0; i_address = 32'd0; d_read = 1'b0; d_write = 1'b0;
    d_address = 32'd0; d_wdata = '0; pmem_resp = 1'b0; pmem_rdata = '0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;

    // Reset state
    settle();
    chk("rst_pmem_read", LW'(pmem_read), LW'(1'b0));
    chk("rst_i_cnt", LW'(i_grant_cnt), LW'(32'd0));
    adv();

    // I-only fill, memory answers on the third SERVE cycle
    i_read = 1'b1; i_address = 32'h0000_0064;
    settle(); adv();
    settle();
    chk("ionly_addr", LW'(pmem_address), LW'(32'h0000_0060));
    chk("ionly_read", LW'(pmem_read), LW'(1'b1));
    adv();
    line = rand_line();
    wait_resp(1, line, 1);
    i_read = 1'b0;
    settle();
    chk("ionly_cnt", LW'(i_grant_cnt), LW'(32'd1));
    adv();

    // D writeback
    d_write = 1'b1; d_address = 32'h8000_0040; d_wdata = aa5;
    settle(); adv();
    settle();
    chk("wb_write", LW'(pmem_write), LW'(1'b1));
    chk("wb_read", LW'(pmem_read), LW'(1'b0));
    chk("wb_wdata", pmem_wdata, aa5);
    chk("wb_addr", LW'(pmem_address), LW'(32'h8000_0040));
    adv();
    wait_resp(0, rand_line(), 2);
    d_write = 1'b0; d_wdata = '0;
    settle(); adv();

    // Requester drops one cycle late: DONE must not reissue
    do_reset();
    i_read = 1'b1; i_address = 32'h0000_1234;
    settle(); adv();
    wait_resp(1, rand_line(), 1);
    settle(); adv();
    i_read = 1'b0;
    repeat (3) begin
      settle();
      chk("hold_no_reissue", LW'(pmem_read), LW'(1'b0));
      adv();
    end
    chk("hold_cnt", LW'(i_grant_cnt), LW'(32'd1));

    // Simultaneous I and D requests
    do_reset();
    i_read = 1'b1; i_address = 32'h0000_0100;
    d_read = 1'b1; d_address = 32'h0000_0200;
    first_addr  = RR ? 32'h0000_0100 : 32'h0000_0200;
    second_addr = RR ? 32'h0000_0200 : 32'h0000_0100;
    first_who   = RR ? 1 : 2;
    second_who  = RR ? 2 : 1;
    settle(); adv();
    settle();
    chk("coll_first", LW'(pmem_address), LW'(first_addr));
    adv();
    wait_resp(0, rand_line(), first_who);
    if (first_who == 1) i_read = 1'b0;
    else d_read = 1'b0;
    settle();
    chk("coll_gap_read", LW'(pmem_read | pmem_write), LW'(1'b0));
    adv();
    settle(); adv();
    settle();
    chk("coll_second", LW'(pmem_address), LW'(second_addr));
    adv();
    wait_resp(1, rand_line(), second_who);
    i_read = 1'b0; d_read = 1'b0;
    settle(); adv();

    // Reset in the middle of a D fill, then a stray memory response
    d_read = 1'b1; d_address = 32'h0000_0300;
    settle(); adv();
    settle(); adv();
    rst = 1'b1; d_read = 1'b0;
    settle(); adv();
    rst = 1'b0;
    settle();
    chk("rst_mid_read", LW'(pmem_read), LW'(1'b0));
    chk("rst_mid_write", LW'(pmem_write), LW'(1'b0));
    chk("rst_mid_dcnt", LW'(d_grant_cnt), LW'(32'd0));
    chk("rst_mid_icnt", LW'(i_grant_cnt), LW'(32'd0));
    adv();
    pmem_resp = 1'b1; pmem_rdata = rand_line();
    settle(); adv();
    pmem_resp = 1'b0; pmem_rdata = '0;
    settle();
    chk("stray_dcnt", LW'(d_grant_cnt), LW'(32'd0));
    chk("stray_read", LW'(pmem_read), LW'(1'b0));
    adv();

    // Counter saturation
    force dut.u_d_cnt.count_r = 32'hFFFF_FFFF;
    m_dcnt = 32'hFFFF_FFFF;
    settle(); adv();
    release dut.u_d_cnt.count_r;
    d_read = 1'b1; d_address = 32'h0000_0440;
    settle(); adv();
    wait_resp(0, rand_line(), 2);
    d_read = 1'b0;
    settle();
    chk("sat_dcnt", LW'(d_grant_cnt), LW'(32'hFFFF_FFFF));
    adv();

    // Randomized traffic against the model
    m_i_done = 1'b0; m_d_done = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (i_late) begin
        i_read = 1'b0; i_late = 1'b0;
      end else if (m_i_done) begin
        m_i_done = 1'b0;
        if ($urandom_range(0, 3) == 0) i_late = 1'b1;
        else i_read = 1'b0;
      end else if (!i_read && $urandom_range(0, 2) == 0) begin
        i_read = 1'b1; i_address = $urandom;
      end
      if (d_late) begin
        d_read = 1'b0; d_write = 1'b0; d_late = 1'b0;
      end else if (m_d_done) begin
        m_d_done = 1'b0;
        if ($urandom_range(0, 3) == 0) d_late = 1'b1;
        else begin d_read = 1'b0; d_write = 1'b0; end
      end else if (!d_read && !d_write && $urandom_range(0, 2) == 0) begin
        op = $urandom_range(0, 2);
        d_read = (op != 1); d_write = (op != 0);
        d_address = $urandom; d_wdata = rand_line();
      end
      pmem_rdata = rand_line();
      if (m_owner != 0) begin
        if (lat_left == 0) pmem_resp = 1'b1;
        else begin pmem_resp = 1'b0; lat_left--; end
      end else begin
        pmem_resp = ($urandom_range(0, 7) == 0);
      end
      settle();
      adv();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
